// File: rtl/rf_bit_requester.sv
// rtl/rf_bit_requester.sv - request-side initiator for a 256 x 1-bit, 1W/2R register file
// Optional post-reset clear sweep enabled by defining RF_REQ_INIT_EN.
module rf_bit_requester #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr_a,
  input  logic [AW-1:0] req_addr_b,
  input  logic          req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [1:0]    rsp_data,
  output logic          init_done,
  output logic [AW-1:0] mem_waddr0,
  output logic          mem_we0,
  output logic          mem_din0,
  output logic [AW-1:0] mem_raddr1,
  input  logic          mem_q1,
  output logic [AW-1:0] mem_raddr2,
  input  logic          mem_q2
);

  logic          run;
  logic          init_we;
  logic [AW-1:0] init_addr;

`ifdef RF_REQ_INIT_EN
  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] init_cnt, init_cnt_nxt;

  // State and sweep counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  // Sweep every address with zero, then hand the file to the client.
  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    init_we      = 1'b0;
    run          = 1'b0;
    case (state)
      S_INIT: begin
        init_we      = 1'b1;
        init_cnt_nxt = init_cnt + 1'b1;
        if (init_cnt == AW'(DEPTH - 1)) state_nxt = S_RUN;
      end
      S_RUN: run = 1'b1;
      default: state_nxt = S_INIT;
    endcase
  end

  assign init_addr = init_cnt;
`else
  // Without the sweep DEPTH only documents the attached file size.
  localparam int unused_depth = DEPTH;

  assign run       = 1'b1;
  assign init_we   = 1'b0;
  assign init_addr = '0;
`endif

  logic [1:0]    fifo_mem [2];
  logic          fifo_rd;
  logic          fifo_wr;
  logic [1:0]    fifo_cnt;
  logic          inflight;
  logic [AW-1:0] raddr1_q;
  logic [AW-1:0] raddr2_q;
  logic [1:0]    outstanding;
  logic          accept, wr_acc, rd_acc;
  logic          pop, pop_fifo, push;

  // A read occupies one credit from acceptance until its response is consumed.
  assign outstanding = {1'b0, inflight} + fifo_cnt;
  assign req_ready   = rst_n && run && (outstanding < 2'd2);
  assign init_done   = rst_n && run;
  assign accept      = req_valid && req_ready;
  assign wr_acc      = accept && req_we;
  assign rd_acc      = accept && !req_we;

  assign mem_we0    = rst_n && (init_we || wr_acc);
  assign mem_waddr0 = wr_acc ? req_addr_a : init_addr;
  assign mem_din0   = wr_acc ? req_wdata : 1'b0;
  assign mem_raddr1 = rd_acc ? req_addr_a : raddr1_q;
  assign mem_raddr2 = rd_acc ? req_addr_b : raddr2_q;

  // Empty FIFO: the file's registered output is presented directly, giving one-cycle latency.
  assign rsp_valid = (fifo_cnt != 2'd0) || inflight;
  assign rsp_data  = (fifo_cnt != 2'd0) ? fifo_mem[fifo_rd] :
                     (inflight ? {mem_q2, mem_q1} : 2'b00);
  assign pop       = rsp_valid && rsp_ready;
  assign pop_fifo  = pop && (fifo_cnt != 2'd0);
  assign push      = inflight && !(pop && (fifo_cnt == 2'd0));

  // In-flight flag, held read addresses and the two-entry response FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight    <= 1'b0;
      raddr1_q    <= '0;
      raddr2_q    <= '0;
      fifo_rd     <= 1'b0;
      fifo_wr     <= 1'b0;
      fifo_cnt    <= 2'd0;
      fifo_mem[0] <= 2'b00;
      fifo_mem[1] <= 2'b00;
    end else begin
      inflight <= rd_acc;
      if (rd_acc) begin
        raddr1_q <= req_addr_a;
        raddr2_q <= req_addr_b;
      end
      if (push) begin
        fifo_mem[fifo_wr] <= {mem_q2, mem_q1};
        fifo_wr           <= ~fifo_wr;
      end
      if (pop_fifo) fifo_rd <= ~fifo_rd;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop_fifo};
    end
  end

endmodule

// File: tb/tb_rf_bit_requester.sv
// tb/tb_rf_bit_requester.sv - scoreboard bench for rf_bit_requester (either RF_REQ_INIT_EN build)
module tb_rf_bit_requester;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_we, req_wdata;
  logic [7:0] req_addr_a, req_addr_b;
  logic       rsp_valid, rsp_ready;
  logic [1:0] rsp_data;
  logic       init_done;
  logic [7:0] mem_waddr0, mem_raddr1, mem_raddr2;
  logic       mem_we0, mem_din0, mem_q1, mem_q2;

  always #5 clk = ~clk;

  rf_bit_requester #(.DEPTH(256), .AW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr_a(req_addr_a), .req_addr_b(req_addr_b), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .init_done(init_done),
    .mem_waddr0(mem_waddr0), .mem_we0(mem_we0), .mem_din0(mem_din0),
    .mem_raddr1(mem_raddr1), .mem_q1(mem_q1),
    .mem_raddr2(mem_raddr2), .mem_q2(mem_q2)
  );

  // Register file: power-on contents all ones so the clear sweep is visible.
  logic fmem [256] = '{default: 1'b1};
  always @(posedge clk) begin
    if (mem_we0) fmem[mem_waddr0] <= mem_din0;
    mem_q1 <= fmem[mem_raddr1];
    mem_q2 <= fmem[mem_raddr2];
  end

  int cyc;
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  logic [1:0] exp_q [$];
  int         rsp_cyc [$];

  // Monitor: every consumed response must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        chk("rsp_data", 32'(rsp_data), 32'(exp_q.pop_front()));
        rsp_cyc.push_back(cyc);
      end
    end
  end

  task automatic issue(input logic we, input logic [7:0] a, input logic [7:0] b,
                       input logic wd, input logic [1:0] exp_d,
                       output int acc_cyc, output int stalls);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr_a = a;
    req_addr_b = b;
    req_wdata  = wd;
    acc_cyc    = -1;
    stalls     = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready) begin
        acc_cyc = cyc;
        break;
      end
      stalls++;
    end
    if (acc_cyc < 0) begin
      chk("accept_timeout", 32'(req_ready), 32'd1);
    end else if (we) begin
      chk("wr_we0", 32'(mem_we0), 32'd1);
      chk("wr_waddr0", 32'(mem_waddr0), 32'(a));
      chk("wr_din0", 32'(mem_din0), 32'(wd));
    end else begin
      chk("rd_raddr1", 32'(mem_raddr1), 32'(a));
      chk("rd_raddr2", 32'(mem_raddr2), 32'(b));
      chk("rd_we0", 32'(mem_we0), 32'd0);
      exp_q.push_back(exp_d);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, st, total, idx0, first_acc, last_acc, pc, bad;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_wdata = 1'b0;
    req_addr_a = 8'h00; req_addr_b = 8'h00; rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_mem_we0", 32'(mem_we0), 32'd0);
    chk("rst_mem_waddr0", 32'(mem_waddr0), 32'd0);
    chk("rst_mem_din0", 32'(mem_din0), 32'd0);
    chk("rst_mem_raddr1", 32'(mem_raddr1), 32'd0);
    chk("rst_mem_raddr2", 32'(mem_raddr2), 32'd0);

    @(posedge clk); #1 rst_n = 1'b1;
`ifdef RF_REQ_INIT_EN
    bad = 0;
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      if (!(mem_we0 === 1'b1 && mem_waddr0 === 8'(c) && mem_din0 === 1'b0 &&
            init_done === 1'b0 && req_ready === 1'b0 && cyc == c)) bad++;
    end
    chk("init_sweep_bad_cycles", 32'(bad), 32'd0);
    @(negedge clk);
    chk("init_done_256", 32'(init_done), 32'd1);
    chk("init_done_cycle", 32'(cyc), 32'd256);
    chk("init_ready_256", 32'(req_ready), 32'd1);
    chk("init_we_off", 32'(mem_we0), 32'd0);
    @(posedge clk); #1;
    issue(1'b0, 8'h00, 8'hFF, 1'b0, 2'b00, acc, st);
`else
    #1;
    chk("c0_init_done", 32'(init_done), 32'd1);
    chk("c0_req_ready", 32'(req_ready), 32'd1);
    chk("c0_mem_we0", 32'(mem_we0), 32'd0);
    issue(1'b0, 8'h10, 8'h20, 1'b0, 2'b11, acc, st);
    chk("c0_accept_cycle", 32'(acc), 32'd0);
    @(negedge clk);
    chk("c1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("c1_rsp_cycle", 32'(cyc), 32'd1);
`endif
    repeat (2) @(posedge clk); #1;

    // Write then read on the next cycle.
    issue(1'b1, 8'h3D, 8'h00, 1'b0, 2'b00, acc, st);
    issue(1'b1, 8'h3C, 8'h00, 1'b1, 2'b00, acc, st);
    issue(1'b0, 8'h3C, 8'h3D, 1'b0, 2'b01, acc, st);
    @(negedge clk);
    chk("raw_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("raw_latency", 32'(cyc - acc), 32'd1);
    repeat (2) @(posedge clk); #1;

    // Streaming over bit[i] = i[0].
    for (int i = 0; i < 16; i++) issue(1'b1, 8'(i), 8'h00, 1'(i % 2), 2'b00, acc, st);
    total = 0; first_acc = 0; last_acc = 0;
    idx0 = rsp_cyc.size();
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, 8'(i), 8'(i + 1), 1'b0, {1'((i + 1) % 2), 1'(i % 2)}, acc, st);
      total += st;
      if (i == 0) first_acc = acc;
      last_acc = acc;
    end
    repeat (3) @(posedge clk); #1;
    chk("stream_stalls", 32'(total), 32'd0);
    chk("stream_accept_span", 32'(last_acc - first_acc), 32'd7);
    chk("stream_rsp_count", 32'(rsp_cyc.size() - idx0), 32'd8);
    if (rsp_cyc.size() >= idx0 + 8)
      chk("stream_rsp_span", 32'(rsp_cyc[idx0 + 7] - rsp_cyc[idx0]), 32'd7);

    // Backpressure: two reads fill the credits, the third waits for a pop.
    rsp_ready = 1'b0;
    issue(1'b0, 8'h00, 8'h01, 1'b0, 2'b10, acc, st);
    issue(1'b0, 8'h01, 8'h02, 1'b0, 2'b01, acc, st);
    req_valid = 1'b1; req_we = 1'b0; req_addr_a = 8'h02; req_addr_b = 8'h03;
    @(negedge clk);
    chk("bp_ready_low_1", 32'(req_ready), 32'd0);
    chk("bp_head_data", 32'(rsp_data), 32'd2);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_ready_low_2", 32'(req_ready), 32'd0);
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_pop_cycle", 32'(req_ready), 32'd0);
    pc = cyc;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_reassert", 32'(req_ready), 32'd1);
    chk("bp_reassert_cycle", 32'(cyc - pc), 32'd1);
    exp_q.push_back(2'b10);
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // Reset with one response buffered and one read in flight.
    rsp_ready = 1'b0;
    issue(1'b0, 8'h04, 8'h05, 1'b0, 2'b10, acc, st);
    issue(1'b0, 8'h05, 8'h06, 1'b0, 2'b01, acc, st);
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
`ifdef RF_REQ_INIT_EN
    chk("mid_rst_init_we", 32'(mem_we0), 32'd1);
    chk("mid_rst_init_addr", 32'(mem_waddr0), 32'd0);
    chk("mid_rst_init_done", 32'(init_done), 32'd0);
    for (int k = 0; k < 300; k++) begin
      if (init_done) break;
      @(negedge clk);
    end
    chk("mid_rst_init_finish", 32'(init_done), 32'd1);
`else
    chk("mid_rst_init_done", 32'(init_done), 32'd1);
    chk("mid_rst_we0", 32'(mem_we0), 32'd0);
`endif
    repeat (5) @(posedge clk); #1;
`ifdef RF_REQ_INIT_EN
    issue(1'b0, 8'h3C, 8'h3D, 1'b0, 2'b00, acc, st);
`else
    issue(1'b0, 8'h3C, 8'h3D, 1'b0, 2'b01, acc, st);
`endif

    for (int k = 0; k < 20; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    #1;
    chk("final_drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rf_bit_requester.md
# rf_bit_requester

Request-side initiator for the 256 x 1-bit register file with one write port and two synchronous read ports. It accepts read/write requests on a valid/ready channel and drives the file's write port and both read ports. It returns paired read data on a valid/ready response channel with backpressure, and optionally clears the whole file after reset. It sits between a client (test sequencer or bitmap consumer) and the storage macro.

## Interface
- DEPTH, 256, entries in the attached file; power of two
- AW, 8, address width, log2(DEPTH)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_we  in  1  1 = write, 0 = dual read
- req_addr_a  in  AW  write address, or first read address
- req_addr_b  in  AW  second read address (ignored on write)
- req_wdata  in  1  write data
- rsp_valid  out  1  read response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_data  out  2  {bit at addr_b, bit at addr_a}
- init_done  out  1  file ready; requests may be accepted
- mem_waddr0  out  AW  write address to file
- mem_we0  out  1  write enable to file
- mem_din0  out  1  write data to file
- mem_raddr1  out  AW  read port 1 address
- mem_q1  in  1  read port 1 data, registered in file (valid 1 cycle after address)
- mem_raddr2  out  AW  read port 2 address
- mem_q2  in  1  read port 2 data, same timing as port 1

## Operation
- FSM states: INIT, RUN.
- INIT: counter walks 0..DEPTH-1. Each cycle mem_we0=1, mem_waddr0=counter, mem_din0=0. Leaves to RUN after writing DEPTH-1.
- RUN: req_ready = (outstanding < 2), where outstanding = in-flight reads + buffered responses.
- Accepted write: mem_we0=1, mem_waddr0=req_addr_a, mem_din0=req_wdata in the same cycle, combinationally. Writes generate no response.
- Accepted read: mem_raddr1=req_addr_a, mem_raddr2=req_addr_b in the same cycle. The in-flight flag sets. Next cycle {mem_q2, mem_q1} is pushed into the 2-entry response FIFO.
- Idle cycles: mem_we0=0. Read addresses hold their last value.
- rsp_data/rsp_valid come from the FIFO head, in request order. The head pops when rsp_valid && rsp_ready.
- A FIFO push and pop in the same cycle leaves occupancy unchanged.
- Read-after-write to the same address in the next cycle returns the new value. The file commits the write at the edge before the read samples, so no forwarding is needed.
- Only one request per cycle, so write and read can never collide in the same cycle.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, init_done=0, mem_we0=0, mem_waddr0=0, mem_din0=0, mem_raddr1=0, mem_raddr2=0. FIFO empty, in-flight clear, FSM=INIT, counter=0.
- Cycle 0 = first cycle with rst_n=1. INIT writes occupy cycles 0..DEPTH-1.
- init_done=1 and req_ready=1 from cycle DEPTH onward.
- Read latency: request accepted in cycle N gives rsp_valid=1 in cycle N+1, provided the FIFO is empty at N+1.
- Throughput: one read per cycle sustained while rsp_ready=1.
- Backpressure with rsp_ready=0:
  - req_ready drops once 2 reads are outstanding.
  - It reasserts in the cycle after a pop.
  - The FIFO never overflows and no response is dropped.
- rst_n=0 at any point is applied at the next edge:
  - the in-flight read and FIFO contents are discarded;
  - all outputs return to reset values;
  - INIT restarts at address 0.

## Configuration
- RF_REQ_INIT_EN defined: INIT sweep as above.
- RF_REQ_INIT_EN undefined:
  - FSM and counter are removed;
  - init_done=1 and req_ready=1 from cycle 0;
  - file contents are undefined until written.

## Test plan
- Init sweep: release reset, hold req_valid=0. Required: mem_we0=1 with addresses 0..255 and din 0 on cycles 0..255, then init_done=1 at cycle 256. A read of (0x00, 0xFF) returns rsp_data=2'b00.
- Write then read: write 1 to 0x3C, then next cycle read (0x3C, 0x3D). Required: rsp_valid one cycle after acceptance, rsp_data=2'b01.
- Streaming: 8 back-to-back reads with rsp_ready=1 over a pattern where bit[i]=i[0]. Required: 8 consecutive responses, in order, with correct pairs, and req_ready never dropping.
- Backpressure: rsp_ready=0, offer 3 reads. Required: the first 2 are accepted and req_ready=0 on the third. Raise rsp_ready: both responses drain in order, and the third is accepted the cycle after the first pop.
- Reset mid-operation: 1 response buffered and 1 read in flight, pulse rst_n=0 for one cycle. Required: rsp_valid=0 next cycle, no stale response ever appears, INIT restarts at address 0.
- Macro off (RF_REQ_INIT_EN undefined): init_done=1 in cycle 0, and a read accepted in cycle 0 returns a response in cycle 1.
